// File: rtl/srt_div_sched_if.sv
// Request/response bundle shared by the requesters, the divider scheduler and
// the response consumer.
interface srt_div_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int NW   = 8,
    parameter int DW   = 6,
    parameter int QW   = 10,
    parameter int RW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ*DW-1:0] req_d;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [QW-1:0]      rsp_q;
    logic [RW-1:0]      rsp_r;
    logic               rsp_dbz;

    modport master (
        output req_valid, req_n, req_d, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );

    modport slave (
        input  req_valid, req_n, req_d, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );
endinterface

// File: rtl/srt_div_sched.sv
// Round-robin scheduler sharing one fixed-latency SRT divider among NREQ
// requesters; divide-by-zero is answered directly without using the divider.
module srt_div_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int NW      = 8,
    parameter int DW      = 6,
    parameter int QW      = 10,
    parameter int RW      = 8,
    parameter int DIV_LAT = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    srt_div_sched_if.slave        bus,
    output logic                  busy,
    output logic                  div_resetn,
    output logic                  div_enable,
    output logic [NW-1:0]         div_n,
    output logic [DW-1:0]         div_d,
    input  logic [QW-1:0]         div_q,
    input  logic [RW-1:0]         div_r
);
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  idx;
    logic            grant_found;
    logic [NW-1:0]   sel_n;
    logic [DW-1:0]   sel_d;
    logic [NW+RW-1:0] n_ext;
    logic [CW-1:0]   cnt;
    logic            xfer;
    logic            run_done;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        sel_n       = '0;
        sel_d       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_n = bus.req_n[i*NW +: NW];
                sel_d = bus.req_d[i*DW +: DW];
            end
        end
    end

    assign n_ext      = {{RW{1'b0}}, sel_n};
    assign xfer       = (state == IDLE) && grant_found;
    assign run_done   = (state == RUN) && (cnt == CW'(DIV_LAT - 1));
    assign busy       = (state != IDLE);
    assign div_resetn = resetn && (state != CLR);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        case (state)
            IDLE: if (grant_found) begin
                bus.req_ready[grant] = 1'b1;
                state_nx = (sel_d == '0) ? RESP : CLR;
            end
            CLR:  state_nx = RUN;
            RUN:  if (run_done) state_nx = RESP;
            RESP: if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr        <= '0;
            cnt           <= '0;
            div_enable    <= 1'b0;
            div_n         <= '0;
            div_d         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_q     <= '0;
            bus.rsp_r     <= '0;
            bus.rsp_dbz   <= 1'b0;
        end else begin
            if (xfer) begin
                rr_ptr     <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                bus.rsp_id <= grant;
                // A zero divisor is answered at once and the divider inputs keep their last values.
                if (sel_d == '0) begin
                    bus.rsp_q     <= '1;
                    bus.rsp_r     <= n_ext[RW-1:0];
                    bus.rsp_dbz   <= 1'b1;
                    bus.rsp_valid <= 1'b1;
                end else begin
                    div_n <= sel_n;
                    div_d <= sel_d;
                end
            end
            if (state == CLR) begin
                cnt        <= '0;
                div_enable <= 1'b1;
            end
            if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (run_done) begin
                    bus.rsp_q     <= div_q;
                    bus.rsp_r     <= div_r;
                    bus.rsp_dbz   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    div_enable    <= 1'b0;
                end
            end
            if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end
endmodule
